// File: rtl/booth_divider.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// then sign correction; results are presented with a one-cycle tx pulse.
module booth_divider #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             tx,
    output logic             dz,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs, dvd_raw;
    logic             sgn_a, sgn_b, dz_r, ovf_r;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             is_zero, is_ovf;

    // Magnitudes are unsigned, so the most-negative operand maps onto 2^(W-1) cleanly.
    always_comb begin
        mag_a   = dividend[WIDTH-1] ? -dividend : dividend;
        mag_b   = divisor[WIDTH-1]  ? -divisor  : divisor;
        is_zero = (divisor == '0);
        is_ovf  = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
        shifted = {rem, quo[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            dvd_raw   <= '0;
            sgn_a     <= 1'b0;
            sgn_b     <= 1'b0;
            dz_r      <= 1'b0;
            ovf_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            tx        <= 1'b0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            tx <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem     <= '0;
                        quo     <= mag_a;
                        dvs     <= mag_b;
                        dvd_raw <= dividend;
                        sgn_a   <= dividend[WIDTH-1];
                        sgn_b   <= divisor[WIDTH-1];
                        dz_r    <= is_zero;
                        ovf_r   <= is_ovf;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (!trial[WIDTH+1]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    // Overflow needs no special path: 2^(W-1) with no negation wraps to -2^(W-1).
                    if (dz_r) begin
                        quotient  <= '1;
                        remainder <= dvd_raw;
                    end else begin
                        quotient  <= (sgn_a ^ sgn_b) ? -quo : quo;
                        remainder <= sgn_a ? -rem : rem;
                    end
                    dz    <= dz_r;
                    ovf   <= ovf_r;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: directed cases, ignored/back-to-back starts,
// mid-run reset, and an exhaustive signed sweep against an integer reference.
module tb_booth_divider;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, tx, dz, ovf;

    booth_divider #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .tx(tx),
        .dz(dz), .ovf(ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        int           due;
        int           a;
        int           b;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: signed integer division truncating toward zero, plus the two special cases.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   q, r;
        e.dz = 1'b0; e.ovf = 1'b0; e.a = a; e.b = b; e.due = 0;
        if (b == 0) begin
            q = -1; r = a; e.dz = 1'b1;
        end else if (a == -(1 << (W-1)) && b == -1) begin
            q = -(1 << (W-1)); r = 0; e.ovf = 1'b1;
        end else begin
            q = a / b; r = a % b;
        end
        e.q = W'(q);
        e.r = W'(r);
        return e;
    endfunction

    always @(negedge CLK) begin
        if (!RST && tx) begin
            if (sb.size() == 0) begin
                chk("unexpected_tx", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("quotient %0d/%0d", e.a, e.b), int'(quotient), int'(e.q));
                chk($sformatf("remainder %0d/%0d", e.a, e.b), int'(remainder), int'(e.r));
                chk($sformatf("dz %0d/%0d", e.a, e.b), int'(dz), int'(e.dz));
                chk($sformatf("ovf %0d/%0d", e.a, e.b), int'(ovf), int'(e.ovf));
                chk($sformatf("tx_cycle %0d/%0d", e.a, e.b), cyc, e.due);
                chk("busy_at_tx", int'(busy), 0);
            end
        end
    end

    // Called at a negedge with the DUT idle; start is accepted at the next posedge.
    task automatic issue(input int a, input int b);
        exp_t e;
        e = model(a, b);
        e.due = cyc + 1 + W + 1;
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        start = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        chk("busy_after_accept", int'(busy), 1);
        @(negedge CLK);
    endtask

    // Returns at the negedge where tx is high.
    task automatic wait_tx();
        int n = 0;
        while (!tx && n < 30) begin
            @(negedge CLK);
            n++;
        end
        if (!tx) chk("tx_timeout", 0, 1);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx", int'(tx), 0);
        chk("rst_dz", int'(dz), 0);
        chk("rst_ovf", int'(ovf), 0);
        RST = 1'b0;
        @(negedge CLK);

        issue(7, -2);  wait_tx();
        issue(-7, 2);  wait_tx();
        issue(-1, 2);  wait_tx();
        issue(6, 3);   wait_tx();
        issue(-8, -1); wait_tx();
        issue(-8, 1);  wait_tx();
        issue(5, 0);   wait_tx();
        issue(3, 2);   wait_tx();

        // start during CALC must be ignored; a start in the tx cycle is accepted.
        @(negedge CLK);
        issue(7, -2);
        dividend = 4'd1; divisor = 4'd1; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        wait_tx();
        issue(-6, 4);
        wait_tx();

        // Reset mid-division aborts without a tx.
        @(negedge CLK);
        issue(7, 3);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        sb.delete();
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_tx", int'(tx), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        chk("midrst_no_tx", int'(tx), 0);
        issue(-8, 3);
        wait_tx();

        for (int a = -(1 << (W-1)); a < (1 << (W-1)); a++)
            for (int b = -(1 << (W-1)); b < (1 << (W-1)); b++) begin
                issue(a, b);
                wait_tx();
            end

        for (int k = 0; k < 40; k++) begin
            issue($urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8);
            wait_tx();
        end

        repeat (10) @(negedge CLK);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
